mem_bist_display: RTL and testbench

Parametrised built-in self-test controller for the team's dual-port RAM. It writes a seeded address-derived pattern through port A, then reads it back through port B, in two passes (true and inverted pattern). It records pass/fail and the first failing address, and drives a row of seven-segment digits with live test data or the final result. It is the successor to the single-width board memory demo and sits between a dual-port RAM instance and the board hex displays.

---
 rtl/mem_bist_pkg.sv | 26 ++
 rtl/hexTo7Seg.sv | 32 +++
 rtl/mem_bist_display.sv | 176 +++++++++++++++++
 tb/tb_mem_bist_display.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bist_pkg.sv
// Shared types and helpers for the dual-port RAM self-test controller.
// Holds the controller state encoding, the default seed and the expected-word rule.
package mem_bist_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ,
    ST_FLUSH,
    ST_DONE
  } state_t;

  localparam logic [15:0] DEFAULT_SEED = 16'hA5C3;

  // Widest word/address the helper handles; callers narrow the result.
  localparam int MAX_W = 64;

  function automatic logic [MAX_W-1:0] expected_word(input logic [MAX_W-1:0] addr,
                                                     input logic [MAX_W-1:0] seed,
                                                     input logic             inv);
    logic [MAX_W-1:0] w;
    w = addr ^ seed;
    return inv ? ~w : w;
  endfunction

endpackage

// File: rtl/hexTo7Seg.sv
// Nibble to seven-segment decoder for the board hex displays.
// Segments are active-low, ordered {g,f,e,d,c,b,a}.
module hexTo7Seg (
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  always_comb begin
    // NOTE: a default before the case keeps this block free of inferred latches.
    seg = 7'h7F;
    case (hex)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      4'hF: seg = 7'h0E;
      default: seg = 7'h7F;
    endcase
  end

endmodule

// File: rtl/mem_bist_display.sv
// Two-pass (true/inverted) write-then-read self-test for a dual-port RAM, with hex readout.
// Define MEM_BIST_HALT_EN to stop at the first mismatch instead of finishing both passes.
module mem_bist_display
  import mem_bist_pkg::*;
#(
  parameter int          DATA_W = 16,
  parameter int          ADDR_W = 10,
  parameter int          DIGITS = DATA_W / 4,
  parameter logic [15:0] SEED   = DEFAULT_SEED
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  output logic [DATA_W-1:0]     mem_data,
  output logic [ADDR_W-1:0]     mem_wr_addr,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_rd_addr,
  input  logic [DATA_W-1:0]     mem_q,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [ADDR_W-1:0]     err_addr,
  output logic [7*DIGITS-1:0]   hex_out
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

`ifdef MEM_BIST_HALT_EN
  localparam logic HALT_EN = 1'b1;
`else
  localparam logic HALT_EN = 1'b0;
`endif

  function automatic logic [DATA_W-1:0] word_at(input logic [ADDR_W-1:0] a, input logic inv);
    return DATA_W'(expected_word(MAX_W'(a), MAX_W'(SEED), inv));
  endfunction

  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] next_addr;
  logic              pass_bit;
  logic              fail;

  // Read data returns one cycle after issue, so the expected word and its
  // address are carried one cycle alongside the outstanding read.
  logic              chk_en;
  logic [DATA_W-1:0] chk_exp;
  logic [ADDR_W-1:0] chk_addr;
  logic [DATA_W-1:0] disp;

  logic              mismatch;
  logic              first_err;
  logic              fail_nx;
  logic              halt_now;
  logic [ADDR_W-1:0] err_nx;
  logic [DATA_W-1:0] done_disp;

  assign next_addr = addr + 1'b1;
  assign mismatch  = chk_en && (state == ST_READ || state == ST_FLUSH) && (mem_q != chk_exp);
  assign first_err = mismatch && !fail;
  assign fail_nx   = fail || mismatch;
  assign err_nx    = first_err ? chk_addr : err_addr;
  assign halt_now  = HALT_EN && first_err;
  assign done_disp = fail_nx ? DATA_W'(err_nx) : '0;

  always_ff @(posedge clock or negedge reset) begin
    // NOTE: the data-path registers are reset too, so the display and RAM
    // ports show a defined value the moment reset asserts.
    if (!reset) begin
      state       <= ST_IDLE;
      addr        <= '0;
      pass_bit    <= 1'b0;
      fail        <= 1'b0;
      chk_en      <= 1'b0;
      chk_exp     <= '0;
      chk_addr    <= '0;
      disp        <= '0;
      mem_data    <= '0;
      mem_wr_addr <= '0;
      mem_we      <= 1'b0;
      mem_rd_addr <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      err_addr    <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout; a later assignment in the
      // same branch deliberately overrides an earlier one (e.g. disp on halt).
      unique case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state       <= ST_WRITE;
            addr        <= '0;
            pass_bit    <= 1'b0;
            fail        <= 1'b0;
            err_addr    <= '0;
            chk_en      <= 1'b0;
            busy        <= 1'b1;
            done        <= 1'b0;
            pass        <= 1'b0;
            mem_we      <= 1'b1;
            mem_wr_addr <= '0;
            mem_data    <= word_at('0, 1'b0);
            disp        <= word_at('0, 1'b0);
          end
        end

        ST_WRITE: begin
          if (addr == LAST_ADDR) begin
            state       <= ST_READ;
            addr        <= '0;
            mem_we      <= 1'b0;
            mem_rd_addr <= '0;
            chk_en      <= 1'b0;
          end else begin
            addr        <= next_addr;
            mem_wr_addr <= next_addr;
            mem_data    <= word_at(next_addr, pass_bit);
            disp        <= word_at(next_addr, pass_bit);
          end
        end

        ST_READ: begin
          chk_en   <= 1'b1;
          chk_exp  <= word_at(addr, pass_bit);
          chk_addr <= addr;
          fail     <= fail_nx;
          err_addr <= err_nx;
          if (chk_en) disp <= mem_q;
          if (halt_now) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= !fail_nx;
            disp  <= done_disp;
          end else if (addr == LAST_ADDR) begin
            state <= ST_FLUSH;
          end else begin
            addr        <= next_addr;
            mem_rd_addr <= next_addr;
          end
        end

        ST_FLUSH: begin
          fail     <= fail_nx;
          err_addr <= err_nx;
          if (!pass_bit && !halt_now) begin
            state       <= ST_WRITE;
            pass_bit    <= 1'b1;
            addr        <= '0;
            mem_we      <= 1'b1;
            mem_wr_addr <= '0;
            mem_data    <= word_at('0, 1'b1);
            disp        <= word_at('0, 1'b1);
          end else begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= !fail_nx;
            disp  <= done_disp;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    hexTo7Seg u_hex (
      .hex (disp[4*(DIGITS-i)-1 -: 4]),
      .seg (hex_out[7*(DIGITS-i)-1 -: 7])
    );
  end

endmodule

// File: tb/tb_mem_bist_display.sv
// Bench for mem_bist_display with a 16-word RAM model, fault injection and a
// timeline model of the expected outputs derived from the test schedule.
module tb_mem_bist_display;

  localparam int D = 16;
  localparam int P = 2 * D + 1;
`ifdef MEM_BIST_HALT_EN
  localparam bit HALT = 1'b1;
`else
  localparam bit HALT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] mem_data;
  logic [3:0]  mem_wr_addr;
  logic        mem_we;
  logic [3:0]  mem_rd_addr;
  logic [15:0] mem_q;
  logic        busy, done, pass;
  logic [3:0]  err_addr;
  logic [27:0] hex_out;

  mem_bist_display #(.DATA_W(16), .ADDR_W(4), .DIGITS(4), .SEED(16'hA5C3)) dut (
    .clock       (clk),
    .reset       (reset),
    .start       (start),
    .mem_data    (mem_data),
    .mem_wr_addr (mem_wr_addr),
    .mem_we      (mem_we),
    .mem_rd_addr (mem_rd_addr),
    .mem_q       (mem_q),
    .busy        (busy),
    .done        (done),
    .pass        (pass),
    .err_addr    (err_addr),
    .hex_out     (hex_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Fault configuration for the RAM read port (-1 = unused).
  int flip_a, flip_b, stuck_a;

  function automatic logic [15:0] e_word(input int a, input int p);
    logic [15:0] w;
    w = 16'(a) ^ 16'hA5C3;
    if (p != 0) w = ~w;
    return w;
  endfunction

  function automatic logic [15:0] ram_fault(input int a, input logic [15:0] v);
    logic [15:0] r;
    r = v;
    if (a == flip_a || a == flip_b) r[0] = ~v[0];
    if (a == stuck_a) r[15] = 1'b1;
    return r;
  endfunction

  function automatic logic [6:0] seg_of(input logic [3:0] n);
    case (n)
      4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
      4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
      4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
      4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
    endcase
  endfunction

  function automatic logic [27:0] seg_word(input logic [15:0] v);
    logic [27:0] s;
    for (int i = 0; i < 4; i++) s[7*i +: 7] = seg_of(v[4*i +: 4]);
    return s;
  endfunction

  // RAM model: synchronous write on port A, registered read on port B.
  logic [15:0] ram [D];
  always @(posedge clk) begin
    if (mem_we) ram[mem_wr_addr] <= mem_data;
    mem_q <= ram_fault(int'(mem_rd_addr), ram[mem_rd_addr]);
  end

  // Model state for the current run.
  bit mdl_on = 1'b0;
  int t_start = 0;
  bit have_err;
  int err_a, err_issue;

  always @(negedge clk) begin
    int rel, p, r, a, t_end;
    if (mdl_on) begin
      rel   = cyc - t_start + 1;
      t_end = (HALT && have_err) ? err_issue + 1 : 2 * P;
      if (rel >= 1 && rel <= t_end) begin
        p = (rel - 1) / P;
        r = (rel - 1) % P;
        check("busy", 32'(busy), 1);
        check("done", 32'(done), 0);
        check("pass", 32'(pass), 0);
        check("err_addr_run", 32'(err_addr), (have_err && rel >= err_issue + 2) ? err_a : 0);
        if (r < D) begin
          check("mem_we", 32'(mem_we), 1);
          check("wr_addr", 32'(mem_wr_addr), r);
          check("wr_data", 32'(mem_data), 32'(e_word(r, p)));
          check("hex_write", 32'(hex_out), 32'(seg_word(e_word(r, p))));
        end else begin
          check("mem_we_idle", 32'(mem_we), 0);
          if (r < 2 * D) begin
            a = r - D;
            check("rd_addr", 32'(mem_rd_addr), a);
            if (a >= 2)
              check("hex_read", 32'(hex_out), 32'(seg_word(ram_fault(a - 2, e_word(a - 2, p)))));
          end else begin
            check("hex_flush", 32'(hex_out), 32'(seg_word(ram_fault(D - 2, e_word(D - 2, p)))));
          end
        end
      end else if (rel > t_end) begin
        check("busy_done", 32'(busy), 0);
        check("done_done", 32'(done), 1);
        check("pass_done", 32'(pass), have_err ? 0 : 1);
        check("we_done", 32'(mem_we), 0);
        check("err_addr_done", 32'(err_addr), have_err ? err_a : 0);
        check("hex_done", 32'(hex_out), 32'(seg_word(have_err ? 16'(err_a) : 16'h0)));
      end
    end
  end

  // Launches one test and returns the number of edges until done was seen.
  task automatic run_test(input int fa, input int fb, input int sa, input bit poke,
                          input int hold, output int n);
    flip_a  = fa;
    flip_b  = fb;
    stuck_a = sa;
    have_err = 1'b0;
    err_a = 0;
    err_issue = 0;
    for (int p = 0; p < 2; p++)
      for (int a = 0; a < D; a++)
        if (!have_err && ram_fault(a, e_word(a, p)) != e_word(a, p)) begin
          have_err  = 1'b1;
          err_a     = a;
          err_issue = p * P + D + a + 1;
        end
    start   = 1'b1;
    t_start = cyc + 1;
    mdl_on  = 1'b1;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
      start = (n < hold) || (poke && (n == 10 || n == 40));
    end while (!done && n < 200);
    start = 1'b0;
    check("done_within_bound", 32'(n < 200), 1);
  endtask

  initial begin
    int n;
    reset  = 1'b0;
    start  = 1'b0;
    flip_a = -1;
    flip_b = -1;
    stuck_a = -1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_pass", 32'(pass), 0);
    check("rst_we", 32'(mem_we), 0);
    check("rst_err_addr", 32'(err_addr), 0);
    check("rst_wr_addr", 32'(mem_wr_addr), 0);
    check("rst_rd_addr", 32'(mem_rd_addr), 0);
    check("rst_data", 32'(mem_data), 0);
    check("rst_hex", 32'(hex_out), 32'({4{7'h40}}));
    reset = 1'b1;
    @(posedge clk);
    #1;

    check("model_e2_p0", 32'(e_word(2, 0)), 32'h0000A5C1);
    check("model_e2_p1", 32'(e_word(2, 1)), 32'h00005A3E);

    // Fault-free run, with start pulses while busy that must be ignored.
    run_test(-1, -1, -1, 1'b1, 1, n);
    check("ideal_cycles", n, 67);
    check("ideal_pass", 32'(pass), 1);
    check("ideal_err_addr", 32'(err_addr), 0);
    check("ideal_hex", 32'(hex_out), 32'({4{7'h40}}));

    // Bit 0 flipped at address 5.
    run_test(5, -1, -1, 1'b0, 1, n);
    check("flip5_cycles", n, 67);
    check("flip5_pass", 32'(pass), 0);
    check("flip5_err_addr", 32'(err_addr), 5);
    check("flip5_hex", 32'(hex_out), 32'({7'h40, 7'h40, 7'h40, 7'h12}));

    // start held high in DONE after a failure restarts with fail/err cleared.
    run_test(-1, -1, -1, 1'b0, 3, n);
    check("restart_cycles", n, 67);
    check("restart_pass", 32'(pass), 1);
    check("restart_err_addr", 32'(err_addr), 0);

    // Two faults: only the first is kept; halting build stops early.
    run_test(3, 9, -1, 1'b0, 1, n);
    check("two_fault_cycles", n, HALT ? 22 : 67);
    check("two_fault_err_addr", 32'(err_addr), 3);
    check("two_fault_pass", 32'(pass), 0);

    // Bit 15 stuck high at address 2: hidden in pass 0, caught in pass 1.
    run_test(-1, -1, 2, 1'b0, 1, n);
    check("stuck_cycles", n, HALT ? 54 : 67);
    check("stuck_err_addr", 32'(err_addr), 2);
    check("stuck_pass", 32'(pass), 0);

    // Asynchronous reset in the middle of the write phase.
    mdl_on  = 1'b0;
    flip_a  = -1;
    flip_b  = -1;
    stuck_a = -1;
    start   = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    check("midwrite_wr_addr", 32'(mem_wr_addr), 7);
    check("midwrite_we", 32'(mem_we), 1);
    #2;
    reset = 1'b0;
    #1;
    check("async_we", 32'(mem_we), 0);
    check("async_busy", 32'(busy), 0);
    check("async_done", 32'(done), 0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    run_test(-1, -1, -1, 1'b0, 1, n);
    check("after_reset_cycles", n, 67);
    check("after_reset_pass", 32'(pass), 1);

    mdl_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
